instr_fetch: RTL and testbench

Fetch stage with IF/ID pipeline register for the RISC-V lab core. It keeps the PC, issues one instruction-memory read at a time, and registers each returned instruction with its PC. Its outputs feed the decode stage, including the immediate generator's instruction input. Stalls come from the hazard unit and redirects come from branch resolution in EX.

---
 rtl/core_pkg.sv | 14 +
 rtl/instr_fetch_if.sv | 25 ++
 rtl/if_id_reg.sv | 47 ++++
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and fetch state encoding for the lab core
package core_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory read bus between fetch and imem
interface instr_fetch_if #(
    parameter int OPERAND_LENGTH = 63
) ();

    logic                    imem_req;
    logic [OPERAND_LENGTH:0] imem_addr;
    logic                    imem_rvalid;
    logic [31:0]             imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with bubble and hold control
module if_id_reg
    import core_pkg::*;
#(
    parameter int          OPERAND_LENGTH = 63,
    parameter logic [31:0] BUBBLE_INSTR   = NOP_INSTR
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    bubble,
    input  logic                    hold,
    input  logic [31:0]             load_instr,
    input  logic [OPERAND_LENGTH:0] load_pc,
    output logic                    id_valid,
    output logic [31:0]             id_instruction,
    output logic [OPERAND_LENGTH:0] id_pc,
    output logic [OPERAND_LENGTH:0] id_pc_plus4
);

    localparam int            W       = OPERAND_LENGTH + 1;
    localparam logic [W-1:0]  PC_STEP = W'(4);

    // Forced bubble beats hold; with no delivery the slot empties but keeps its PC
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid       <= 1'b0;
            id_instruction <= BUBBLE_INSTR;
            id_pc          <= '0;
            id_pc_plus4    <= PC_STEP;
        end else if (bubble) begin
            id_valid       <= 1'b0;
            id_instruction <= BUBBLE_INSTR;
        end else if (hold) begin
            id_valid       <= id_valid;
        end else if (load) begin
            id_valid       <= 1'b1;
            id_instruction <= load_instr;
            id_pc          <= load_pc;
            id_pc_plus4    <= load_pc + PC_STEP;
        end else begin
            id_valid       <= 1'b0;
            id_instruction <= BUBBLE_INSTR;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding fetch stage feeding the IF/ID register
module instr_fetch #(
    parameter int                      OPERAND_LENGTH = 63,
    parameter logic [OPERAND_LENGTH:0] RESET_PC       = (OPERAND_LENGTH + 1)'(core_pkg::DEFAULT_RESET_PC),
    parameter logic [31:0]             NOP_INSTR      = core_pkg::NOP_INSTR
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [OPERAND_LENGTH:0] redirect_pc,
    instr_fetch_if.master           imem,
    output logic                    id_valid,
    output logic [31:0]             id_instruction,
    output logic [OPERAND_LENGTH:0] id_pc,
    output logic [OPERAND_LENGTH:0] id_pc_plus4
);

    localparam int           W       = OPERAND_LENGTH + 1;
    localparam logic [W-1:0] PC_STEP = W'(4);

    core_pkg::fetch_state_t state_q;
    core_pkg::fetch_state_t state_d;
    logic [W-1:0]           pc_q;
    logic [31:0]            buf_q;
    logic                   deliver;
    logic                   buf_load;
    logic [31:0]            deliver_instr;
    logic [W-1:0]           redirect_target;
    logic                   redirect_lsb_unused;

    // Targets are word aligned; the low two bits of the redirect are dropped
    assign redirect_target     = {redirect_pc[OPERAND_LENGTH:2], 2'b00};
    assign redirect_lsb_unused = |redirect_pc[1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= core_pkg::FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a redirect turns any outstanding request stale
    always_comb begin
        state_d = state_q;
        case (state_q)
            core_pkg::FETCH: begin
                state_d = redirect_valid ? core_pkg::DROP : core_pkg::WAIT;
            end
            core_pkg::WAIT: begin
                if (redirect_valid) begin
                    state_d = imem.imem_rvalid ? core_pkg::FETCH : core_pkg::DROP;
                end else if (imem.imem_rvalid) begin
                    state_d = stall ? core_pkg::HOLD : core_pkg::FETCH;
                end
            end
            core_pkg::HOLD: begin
                if (redirect_valid || !stall) begin
                    state_d = core_pkg::FETCH;
                end
            end
            core_pkg::DROP: begin
                if (imem.imem_rvalid) begin
                    state_d = core_pkg::FETCH;
                end
            end
            default: state_d = core_pkg::FETCH;
        endcase
    end

    // Outputs: request in FETCH only, delivery from the bus or the buffer
    always_comb begin
        imem.imem_req  = (state_q == core_pkg::FETCH) && !reset;
        imem.imem_addr = pc_q;
        deliver        = !redirect_valid && !stall &&
                         (((state_q == core_pkg::WAIT) && imem.imem_rvalid) ||
                          (state_q == core_pkg::HOLD));
        deliver_instr  = (state_q == core_pkg::HOLD) ? buf_q : imem.imem_rdata;
        buf_load       = !redirect_valid && stall &&
                         (state_q == core_pkg::WAIT) && imem.imem_rvalid;
    end

    // PC advances on delivery, jumps on redirect; buffer catches a stalled response
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            buf_q <= '0;
        end else begin
            if (redirect_valid) begin
                pc_q <= redirect_target;
            end else if (deliver) begin
                pc_q <= pc_q + PC_STEP;
            end
            if (redirect_valid) begin
                buf_q <= '0;
            end else if (buf_load) begin
                buf_q <= imem.imem_rdata;
            end
        end
    end

    // A response with no request outstanding means the memory broke the protocol
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (reset)
        !(imem.imem_rvalid && ((state_q == core_pkg::FETCH) || (state_q == core_pkg::HOLD))));

    if_id_reg #(
        .OPERAND_LENGTH (OPERAND_LENGTH),
        .BUBBLE_INSTR   (NOP_INSTR)
    ) u_if_id_reg (
        .clk            (clk),
        .reset          (reset),
        .load           (deliver),
        .bubble         (redirect_valid),
        .hold           (stall),
        .load_instr     (deliver_instr),
        .load_pc        (pc_q),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for the fetch stage and IF/ID register
module tb_instr_fetch;
    import core_pkg::*;

    localparam int OL = 63;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [63:0] id_pc;
    logic [63:0] id_pc_plus4;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;
    int          lat = 1;

    instr_fetch_if #(.OPERAND_LENGTH(OL)) mif ();

    instr_fetch #(
        .OPERAND_LENGTH (OL),
        .RESET_PC       (64'h0),
        .NOP_INSTR      (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (mif),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h0050_0093;
        if (a == 64'h4) return 32'h00a0_0113;
        return {a[15:0], 16'h0113};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // Memory model: fixed latency 'lat' cycles after the accepting edge
    logic        req_n = 1'b0;
    logic [63:0] addr_n = '0;
    logic [63:0] paddr = '0;
    int          cnt = 0;

    initial begin
        mif.imem_rvalid = 1'b0;
        mif.imem_rdata  = '0;
    end

    always @(negedge clk) begin
        req_n  = mif.imem_req;
        addr_n = mif.imem_addr;
    end

    always @(posedge clk) begin
        #1;
        mif.imem_rvalid = 1'b0;
        if (reset) begin
            cnt = 0;
        end else begin
            if (req_n) begin
                cnt   = lat;
                paddr = addr_n;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mif.imem_rvalid = 1'b1;
                    mif.imem_rdata  = mem_word(paddr);
                end
            end
        end
    end

    // Monitor: a valid ID slot after a non-stalled edge is a fresh delivery
    bit prev_stall = 1'b1;
    always @(negedge clk) begin
        exp_t e;
        if (!done) begin
            if (id_valid && !prev_stall) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery: got id_pc 0x%0h expected none", id_pc);
                end else begin
                    e = sb.pop_front();
                    check("id_pc", id_pc, e.pc);
                    check("id_instruction", {32'h0, id_instruction}, {32'h0, e.instr});
                    check("id_pc_plus4", id_pc_plus4, e.pc + 64'd4);
                end
            end
            if (!id_valid) check("bubble_instr", {32'h0, id_instruction}, {32'h0, NOP_INSTR});
            prev_stall = stall;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(input logic [63:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mif.imem_req && (mif.imem_addr == a)) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        check($sformatf("req_at_0x%0h", a), {63'h0, found}, 64'h1);
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        sb.push_back('{pc: 64'h0, instr: 32'h0050_0093});
        sb.push_back('{pc: 64'h4, instr: 32'h00a0_0113});
        sb.push_back('{pc: 64'h8, instr: 32'h0008_0113});
        sb.push_back('{pc: 64'hC, instr: 32'h000C_0113});

        cyc();
        check("rst_req", {63'h0, mif.imem_req}, 64'h0);
        check("rst_valid", {63'h0, id_valid}, 64'h0);
        check("rst_instr", {32'h0, id_instruction}, 64'h13);
        check("rst_pc", id_pc, 64'h0);
        check("rst_pc_plus4", id_pc_plus4, 64'h4);
        cyc();
        check("rst_req_2", {63'h0, mif.imem_req}, 64'h0);
        reset = 1'b0;
        #1;
        check("first_req", {63'h0, mif.imem_req}, 64'h1);
        check("first_addr", mif.imem_addr, 64'h0);

        cyc();
        check("wait_no_req", {63'h0, mif.imem_req}, 64'h0);
        cyc();
        check("d0_valid", {63'h0, id_valid}, 64'h1);
        check("d0_pc", id_pc, 64'h0);
        check("d0_plus4", id_pc_plus4, 64'h4);
        check("req_addr_4", mif.imem_addr, 64'h4);
        cyc();
        check("gap_valid", {63'h0, id_valid}, 64'h0);
        cyc();
        check("d1_valid", {63'h0, id_valid}, 64'h1);
        check("d1_pc", id_pc, 64'h4);
        check("d1_plus4", id_pc_plus4, 64'h8);

        // Stall across the response for 0x8
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("frozen_valid", {63'h0, id_valid}, 64'h1);
            check("frozen_pc", id_pc, 64'h4);
            check("frozen_instr", {32'h0, id_instruction}, 64'h00a0_0113);
        end
        stall = 1'b0;
        cyc();
        check("unstall_pc", id_pc, 64'h8);
        check("unstall_instr", {32'h0, id_instruction}, 64'h0008_0113);
        check("unstall_req", {63'h0, mif.imem_req}, 64'h1);
        check("unstall_addr", mif.imem_addr, 64'hC);

        // Redirect while waiting on 0x10 with a slow response
        sb.push_back('{pc: 64'h100, instr: 32'h0100_0113});
        wait_req(64'h10);
        lat = 2;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        cyc();
        redirect_valid = 1'b0;
        lat = 1;
        check("redir_bubble", {63'h0, id_valid}, 64'h0);
        check("redir_nop", {32'h0, id_instruction}, 64'h13);
        check("redir_keep_pc", id_pc, 64'hC);
        check("drop_no_req", {63'h0, mif.imem_req}, 64'h0);
        wait_req(64'h100);

        // Redirect coinciding with the response in WAIT
        sb.push_back('{pc: 64'h200, instr: 32'h0200_0113});
        wait_req(64'h104);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        cyc();
        redirect_valid = 1'b0;
        check("same_cyc_bubble", {63'h0, id_valid}, 64'h0);
        check("same_cyc_req", {63'h0, mif.imem_req}, 64'h1);
        check("same_cyc_addr", mif.imem_addr, 64'h200);

        // Redirect under stall while a word sits in the buffer
        sb.push_back('{pc: 64'h300, instr: 32'h0300_0113});
        wait_req(64'h204);
        stall = 1'b1;
        cyc();
        cyc();
        check("hold_valid", {63'h0, id_valid}, 64'h1);
        check("hold_pc", id_pc, 64'h200);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h300;
        cyc();
        redirect_valid = 1'b0;
        stall = 1'b0;
        check("hold_redir_bubble", {63'h0, id_valid}, 64'h0);
        check("hold_redir_nop", {32'h0, id_instruction}, 64'h13);
        check("hold_redir_keep_pc", id_pc, 64'h200);
        check("hold_redir_req", {63'h0, mif.imem_req}, 64'h1);
        check("hold_redir_addr", mif.imem_addr, 64'h300);

        // PC wrap at the top of the address space
        wait_req(64'h304);
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        check("fetch_redir_drop", {63'h0, mif.imem_req}, 64'h0);
        sb.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, instr: 32'hFFFC_0113});
        wait_req(64'hFFFF_FFFF_FFFF_FFFC);
        wait_req(64'h0);
        stall = 1'b1;
        check("wrap_valid", {63'h0, id_valid}, 64'h1);
        check("wrap_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_pc_plus4", id_pc_plus4, 64'h0);

        repeat (4) cyc();
        check("scoreboard_drained", 64'(sb.size()), 64'h0);
        done = 1'b1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
